// File: rtl/fec_decoder.sv
// Extended-Hamming (SEC-DED) decoder: pulls codewords from a FIFO, corrects single errors,
// flags double/out-of-range errors and keeps saturating error counters.
module fec_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_BITS = 4,
    parameter int CNT_WIDTH   = 16,
    localparam int CODE_WIDTH = DATA_WIDTH + PARITY_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_valid,
    input  logic [CODE_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_corrected,
    output logic                  err_uncorrectable,
    input  logic                  clear_counters,
    output logic [CNT_WIDTH-1:0]  cnt_corrected,
    output logic [CNT_WIDTH-1:0]  cnt_uncorrectable
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DECODE, OUT} state_t;

    state_t                  state;
    logic [CODE_WIDTH-1:0]   code;
    logic [PARITY_BITS-1:0]  syn;
    logic                    par;
    logic                    in_range;
    logic                    fix_bit;
    logic                    dec_corr;
    logic                    dec_unc;
    logic [DATA_WIDTH-1:0]   dec_data;

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODE_WIDTH-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int unsigned           k;
        d = '0;
        k = 0;
        for (int unsigned i = 3; i < CODE_WIDTH; i++) begin
            if (((i & (i - 1)) != 0) && (k < DATA_WIDTH)) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    always_comb begin
        syn = '0;
        for (int unsigned i = 1; i < CODE_WIDTH; i++) begin
            if (code[i]) syn ^= PARITY_BITS'(i);
        end
        par      = ^code;
        in_range = int'(syn) < CODE_WIDTH;
        // s=0 with odd parity is a bit-0 error: counted as corrected, data untouched
        dec_corr = par && in_range;
        dec_unc  = (syn != '0) && !dec_corr;
        fix_bit  = dec_corr && (syn != '0);
        dec_data = extract(fix_bit ? (code ^ (CODE_WIDTH'(1) << syn)) : code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            fifo_rd_en        <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            code              <= '0;
            cnt_corrected     <= '0;
            cnt_uncorrectable <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    fifo_rd_en <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (fifo_rd_valid) begin
                        code  <= fifo_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    out_data          <= dec_data;
                    err_corrected     <= dec_corr;
                    err_uncorrectable <= dec_unc;
                    out_valid         <= 1'b1;
                    state             <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (clear_counters) begin
                cnt_corrected     <= '0;
                cnt_uncorrectable <= '0;
            end else if (state == DECODE) begin
                if (dec_corr && (cnt_corrected != '1))
                    cnt_corrected <= cnt_corrected + 1'b1;
                if (dec_unc && (cnt_uncorrectable != '1))
                    cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
            end
        end
    end

endmodule
